// File: rtl/imul_int_mul_var_nbits_if.sv
// Request/response val/rdy bundle for the iterative integer multiplier.
interface imul_int_mul_var_nbits_if #(
    parameter int p_nbits = 32
);
    logic                 req_val;
    logic                 req_rdy;
    logic [2*p_nbits-1:0] req_msg;
    logic [1:0]           req_mode;
    logic                 resp_val;
    logic                 resp_rdy;
    logic [p_nbits-1:0]   resp_msg;

    modport master (
        output req_val, req_msg, req_mode, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, req_mode, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );
endinterface

// File: rtl/imul_int_mul_var_nbits.sv
// Variable-latency shift-add multiplier with zero-skip shifting and RISC-V result modes.
// Optional IMUL_OPERAND_SWAP_EN puts the smaller magnitude in the multiplier register.
module imul_int_mul_var_nbits #(
    parameter int p_nbits     = 32,
    parameter int p_max_shamt = 16
) (
    input logic                     clk,
    input logic                     reset,
    imul_int_mul_var_nbits_if.slave io
);
    localparam int N  = p_nbits;
    localparam int LG = $clog2(p_max_shamt);

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_MULH   = 2'b01;
    localparam logic [1:0] MODE_MULHSU = 2'b11;

    localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [2*N-1:0] a_q, a_d;
    logic [2*N-1:0] result_q, result_d;
    logic [N-1:0]   b_q, b_d;
    logic           neg_q, neg_d;
    logic [1:0]     mode_q, mode_d;

    logic signed [N-1:0] a_in, b_in;
    logic                a_sgn, b_sgn;
    logic [N-1:0]        a_mag, b_mag, big_mag, small_mag;
    logic                req_go, resp_go, calc_done;
    int                  shamt;
    logic [2*N-1:0]      prod;

    assign req_go    = io.req_val & io.req_rdy;
    assign resp_go   = io.resp_val & io.resp_rdy;
    assign calc_done = (a_q == '0) || (b_q == '0);

    // Operand signedness depends on mode; MUL and MULHU use raw unsigned magnitudes.
    always_comb begin
        a_in  = $signed(io.req_msg[2*N-1:N]);
        b_in  = $signed(io.req_msg[N-1:0]);
        a_sgn = ((io.req_mode == MODE_MULH) || (io.req_mode == MODE_MULHSU)) && a_in[N-1];
        b_sgn = (io.req_mode == MODE_MULH) && b_in[N-1];
        a_mag = a_sgn ? $unsigned(-a_in) : $unsigned(a_in);
        b_mag = b_sgn ? $unsigned(-b_in) : $unsigned(b_in);
`ifdef IMUL_OPERAND_SWAP_EN
        if (b_mag > a_mag) begin
            big_mag   = b_mag;
            small_mag = a_mag;
        end else begin
            big_mag   = a_mag;
            small_mag = b_mag;
        end
`else
        big_mag   = a_mag;
        small_mag = b_mag;
`endif
    end

    // Largest power-of-two skip whose low bits of the multiplier are all zero.
    always_comb begin
        shamt = 1;
        for (int i = 1; i <= LG; i++) begin
            if ((b_q & ((ONE_N << (1 << i)) - ONE_N)) == '0) shamt = 1 << i;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        neg_d    = neg_q;
        mode_d   = mode_q;
        case (state_q)
            IDLE: begin
                if (req_go) begin
                    state_d  = CALC;
                    a_d      = {{N{1'b0}}, big_mag};
                    b_d      = small_mag;
                    result_d = '0;
                    neg_d    = a_sgn ^ b_sgn;
                    mode_d   = io.req_mode;
                end
            end
            CALC: begin
                if (calc_done) begin
                    state_d = DONE;
                end else if (b_q[0]) begin
                    result_d = result_q + a_q;
                    a_d      = a_q << 1;
                    b_d      = b_q >> 1;
                end else begin
                    a_d = a_q << shamt;
                    b_d = b_q >> shamt;
                end
            end
            DONE: begin
                if (resp_go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            mode_q   <= MODE_MUL;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            mode_q   <= mode_d;
        end
    end

    assign prod = neg_q ? (~result_q + ONE_2N) : result_q;

    assign io.req_rdy  = (state_q == IDLE) && reset;
    assign io.resp_val = (state_q == DONE);
    assign io.resp_msg = (state_q != DONE)     ? '0 :
                         (mode_q == MODE_MUL) ? prod[N-1:0] : prod[2*N-1:N];
endmodule

// File: tb/tb_imul_int_mul_var_nbits.sv
// Directed bench for the 32-bit multiplier plus a 16-bit instance against a reference model.
module tb_imul_int_mul_var_nbits;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    imul_int_mul_var_nbits_if #(.p_nbits(32)) io32();
    imul_int_mul_var_nbits_if #(.p_nbits(16)) io16();

    imul_int_mul_var_nbits #(.p_nbits(32), .p_max_shamt(16)) dut32 (
        .clk(clk), .reset(reset), .io(io32.slave)
    );
    imul_int_mul_var_nbits #(.p_nbits(16), .p_max_shamt(4)) dut16 (
        .clk(clk), .reset(reset), .io(io16.slave)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; returns after the accepting posedge (+1).
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
        int w;
        @(negedge clk);
        w = 0;
        while (io32.req_rdy !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk1("req_rdy_before_issue", io32.req_rdy, 1'b1);
        io32.req_val  = 1'b1;
        io32.req_msg  = {a, b};
        io32.req_mode = mode;
        @(posedge clk);
        #1 io32.req_val = 1'b0;
    endtask

    // Called right after the accepting edge; cyc is the cycle index where resp_val is seen.
    task automatic wait_resp32(output logic [31:0] msg, output int cyc);
        cyc = 1;
        @(negedge clk);
        while (io32.resp_val !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk1("resp_val_timeout", io32.resp_val, 1'b1);
        msg = io32.resp_msg;
    endtask

    task automatic drain32();
        io32.resp_rdy = 1'b1;
        @(posedge clk);
        #1 io32.resp_rdy = 1'b0;
    endtask

    task automatic req32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                         output logic [31:0] msg, output int cyc);
        issue32(a, b, mode);
        wait_resp32(msg, cyc);
        drain32();
    endtask

    task automatic req16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] mode,
                         output logic [15:0] msg);
        int w;
        @(negedge clk);
        w = 0;
        while (io16.req_rdy !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        io16.req_val  = 1'b1;
        io16.req_msg  = {a, b};
        io16.req_mode = mode;
        @(posedge clk);
        #1 io16.req_val = 1'b0;
        w = 0;
        @(negedge clk);
        while (io16.resp_val !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk1("n16_resp_val_timeout", io16.resp_val, 1'b1);
        msg = io16.resp_msg;
        io16.resp_rdy = 1'b1;
        @(posedge clk);
        #1 io16.resp_rdy = 1'b0;
    endtask

    initial begin
        logic [31:0]        m;
        int                 c;
        logic [15:0]        a16, b16, got16, exp16;
        logic [1:0]         md;
        logic signed [31:0] sa, sb;
        logic [31:0]        p;

        io32.req_val = 1'b0; io32.req_msg = '0; io32.req_mode = 2'b00; io32.resp_rdy = 1'b0;
        io16.req_val = 1'b0; io16.req_msg = '0; io16.req_mode = 2'b00; io16.resp_rdy = 1'b0;
        reset = 1'b0;

        // Reset held low for three cycles.
        repeat (3) begin
            @(negedge clk);
            chk1("rst_req_rdy", io32.req_rdy, 1'b0);
            chk1("rst_resp_val", io32.resp_val, 1'b0);
        end
        chk32("rst_resp_msg", io32.resp_msg, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk1("post_rst_req_rdy", io32.req_rdy, 1'b1);
        chk1("post_rst_resp_val", io32.resp_val, 1'b0);
        chk32("post_rst_resp_msg", io32.resp_msg, 32'h0);

        // Basic MUL and its latency.
        req32(32'd3, 32'd5, 2'b00, m, c);
        chk32("mul_3x5", m, 32'h0000000F);
`ifdef IMUL_OPERAND_SWAP_EN
        chk32("mul_3x5_latency", c, 32'd4);
`else
        chk32("mul_3x5_latency", c, 32'd5);
`endif

        // Zero operand exits immediately.
        req32(32'h0, 32'h12345678, 2'b00, m, c);
        chk32("mul_zero", m, 32'h0);
        chk32("mul_zero_latency", c, 32'd2);
        req32(32'h00010000, 32'h80000000, 2'b00, m, c);
        chk32("mul_wide_skip", m, 32'h0);

        // All four modes at signed boundaries.
        req32(32'hFFFFFFFE, 32'd3, 2'b01, m, c);
        chk32("mulh_m2x3", m, 32'hFFFFFFFF);
        req32(32'hFFFFFFFE, 32'd3, 2'b00, m, c);
        chk32("mul_m2x3", m, 32'hFFFFFFFA);
        req32(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, m, c);
        chk32("mulhu_max", m, 32'hFFFFFFFE);
        req32(32'hFFFFFFFF, 32'd2, 2'b11, m, c);
        chk32("mulhsu_m1x2", m, 32'hFFFFFFFF);
        req32(32'h80000000, 32'h80000000, 2'b01, m, c);
        chk32("mulh_minxmin", m, 32'h40000000);

        // Backpressure: response held stable for ten cycles.
        issue32(32'd7, 32'd6, 2'b00);
        wait_resp32(m, c);
        chk32("bp_first", m, 32'h0000002A);
        repeat (10) begin
            @(negedge clk);
            chk1("bp_resp_val", io32.resp_val, 1'b1);
            chk32("bp_resp_msg", io32.resp_msg, 32'h0000002A);
            chk1("bp_req_rdy", io32.req_rdy, 1'b0);
        end
        io32.resp_rdy = 1'b1;
        @(posedge clk);
        #1 io32.resp_rdy = 1'b0;
        io32.req_val  = 1'b1;
        io32.req_msg  = {32'd9, 32'd9};
        io32.req_mode = 2'b00;
        @(negedge clk);
        chk1("b2b_req_rdy", io32.req_rdy, 1'b1);
        chk1("b2b_resp_val_low", io32.resp_val, 1'b0);
        @(posedge clk);
        #1 io32.req_val = 1'b0;
        wait_resp32(m, c);
        chk32("b2b_mul_9x9", m, 32'h00000051);
        drain32();

        // Reset in the middle of a long calculation.
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00);
        @(negedge clk);
        @(negedge clk);
        chk1("midcalc_busy", io32.req_rdy, 1'b0);
        reset = 1'b0;
        #1;
        chk1("midcalc_rst_req_rdy", io32.req_rdy, 1'b0);
        chk1("midcalc_rst_resp_val", io32.resp_val, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk1("after_abort_req_rdy", io32.req_rdy, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk1("after_abort_no_resp", io32.resp_val, 1'b0);
        end
        req32(32'd7, 32'd6, 2'b00, m, c);
        chk32("after_abort_7x6", m, 32'h0000002A);

        // 16-bit instance against a reference product.
        for (int i = 0; i < 24; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            md  = 2'($urandom_range(3, 0));
            if (i == 0) begin a16 = 16'h8000; b16 = 16'h8000; md = 2'b01; end
            if (i == 1) begin a16 = 16'hFFFF; b16 = 16'hFFFF; md = 2'b10; end
            if (i == 2) begin a16 = 16'hFFFF; b16 = 16'h0002; md = 2'b11; end
            if (i == 3) begin a16 = 16'h0000; b16 = 16'h1234; md = 2'b00; end
            sa = $signed(a16);
            sb = $signed(b16);
            case (md)
                2'b00, 2'b01: p = sa * sb;
                2'b10:        p = {16'h0, a16} * {16'h0, b16};
                default:      p = sa * {16'h0, b16};
            endcase
            exp16 = (md == 2'b00) ? p[15:0] : p[31:16];
            req16(a16, b16, md, got16);
            chk16("n16_product", got16, exp16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imul_int_mul_var_nbits.md
Name: imul_int_mul_var_nbits

Overview:
Parametrised variable-latency iterative integer multiplier with val/rdy request and response interfaces. It is the successor to the fixed 32-bit shift-add multiplier and adds three things: operand width as a parameter, four RISC-V-style result modes (low half, signed/unsigned/mixed high half), and a configurable maximum zero-skip shift. It sits behind the processor's multiply unit and in the lab1_imul test harness.

Parameters:
p_nbits, 32, operand and result width; must be even and at least 8.
p_max_shamt, 16, largest single-cycle zero-skip shift; must be a power of 2 in the range 1..p_nbits/2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
req_val  in  1  request valid.
req_rdy  out  1  request ready.
req_msg  in  2*p_nbits  {a[2N-1:N], b[N-1:0]}, where N = p_nbits.
req_mode  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHU (u×u high), 11 MULHSU (a signed × b unsigned, high half).
resp_val  out  1  response valid.
resp_rdy  in  1  response ready.
resp_msg  out  p_nbits  selected half of the 2N-bit product.

Behaviour:
- Handshake: req_go = req_val & req_rdy; resp_go = resp_val & resp_rdy.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on req_go.
  - CALC -> DONE when a_reg==0 or b_reg==0 (registered values).
  - DONE -> IDLE on resp_go.
- Outputs per state:
  - req_rdy = 1 only in IDLE.
  - resp_val = 1 only in DONE.
  - Exactly one transaction is in flight; no request is accepted in CALC or DONE.
- Load (on req_go edge):
  - a_reg (2N wide) <= |a| zero-extended; b_reg (N wide) <= |b|; result (2N) <= 0.
  - mode_reg <= req_mode.
  - neg_reg <= sign(a) XOR sign(b), using signedness per mode: MUL and MULHU treat both unsigned; MULHSU treats only a as signed.
  - For MUL, magnitudes are taken as unsigned; the low half is sign-agnostic.
- CALC cycle, when the exit condition is false:
  - If b_reg[0] = 1: result += a_reg; a_reg <<= 1; b_reg >>= 1.
  - Otherwise, let k be the largest value in {p_max_shamt, ..., 2, 1} with b_reg[k-1:0] == 0; then a_reg <<= k and b_reg >>= k, and result holds.
  - When the exit condition is true, no datapath register changes that cycle.
- Arithmetic:
  - All adds and shifts are modulo 2N.
  - Final product P = neg_reg ? (~result + 1) : result, computed combinationally from the registered values.
  - resp_msg = P[N-1:0] for MUL, P[2N-1:N] otherwise.
  - resp_msg is valid only while in DONE.
- Latency:
  - req_go in cycle 0; CALC occupies cycles 1 .. S+1, where S = number of non-exit CALC steps; resp_val first asserts in cycle S+2.
  - A zero operand gives S = 0, so resp_val asserts in cycle 2.
- Backpressure: while in DONE with resp_rdy = 0, resp_val and resp_msg stay stable.
- Overlap: a new req_go is possible in the cycle after resp_go. There is no same-cycle IDLE bypass.
- Reset:
  - Asynchronous; forces IDLE and clears a_reg, b_reg, result, neg_reg and mode_reg.
  - While reset is asserted, req_rdy = 0, resp_val = 0, resp_msg = 0.
  - Reset mid-CALC or mid-DONE aborts the transaction silently.
  - After deassertion, req_rdy = 1 on the next evaluated cycle.
- Edge case: most-negative operands (e.g. 0x80000000) have magnitude 2^(N-1) as an unsigned N-bit value, which is correct by construction.

Optional Feature:
IMUL_OPERAND_SWAP_EN
- Defined: at load, the smaller magnitude goes to b_reg and the larger to a_reg (a on a tie). The product is unchanged; latency is usually reduced.
- Undefined: a magnitude -> a_reg and b magnitude -> b_reg always. The bench derives expected latency from whichever setting is compiled in.

Test Plan:
1. Reset low for 3 cycles, then high -> req_rdy = 0 and resp_val = 0 during reset; req_rdy = 1 after release; resp_msg = 0.
2. MUL, a = 3, b = 5, req_go in cycle 0 -> resp_msg = 0x0000000F. Without swap, resp_val in cycle 5 (add, skip1, add, exit). With IMUL_OPERAND_SWAP_EN, resp_val in cycle 4.
3. MUL, a = 0, b = 0x12345678 -> resp_val in cycle 2 with resp_msg = 0. Also a = 0x00010000, b = 0x80000000 (no swap) -> 16-bit skip used, resp_msg = 0.
4. Each mode with signed-boundary operands:
   - MULH a = 0xFFFFFFFE, b = 3 -> 0xFFFFFFFF.
   - MUL, same operands -> 0xFFFFFFFA.
   - MULHU a = b = 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU a = 0xFFFFFFFF, b = 2 -> 0xFFFFFFFF.
   - MULH a = b = 0x80000000 -> 0x40000000.
5. Backpressure: hold resp_rdy = 0 for 10 cycles in DONE -> resp_val and resp_msg held stable, req_rdy = 0. Then resp_rdy = 1 -> IDLE next cycle, and a back-to-back request is accepted.
6. Assert reset mid-CALC on a 0xFFFFFFFF × 0xFFFFFFFF MUL -> immediate IDLE, no resp_val. A following 7 × 6 MUL -> resp_msg = 0x0000002A. Repeat with p_nbits = 16, p_max_shamt = 4 against a random-operand reference model.
